mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the data-memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_NCORES  = 2;
  localparam int DEF_TIMEOUT = 255;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting after the last served core
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NCORES = DEF_NCORES,
  parameter int IW     = idx_w(NCORES)
) (
  input  logic [NCORES-1:0] req,
  input  logic [IW-1:0]     last,
  output logic [NCORES-1:0] grant,
  output logic [IW-1:0]     id
);

  logic [IW-1:0] cand;

  // Scan farthest-first so the nearest requester after last wins.
  always_comb begin
    grant = '0;
    id    = '0;
    cand  = '0;
    for (int off = NCORES; off >= 1; off--) begin
      cand = IW'((int'(last) + off) % NCORES);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        id          = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one data memory among the cores
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NCORES  = DEF_NCORES,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    core_req,
  input  logic [NCORES-1:0]    core_we,
  input  logic [NCORES*AW-1:0] core_addr,
  input  logic [NCORES*DW-1:0] core_wdata,
  output logic [NCORES-1:0]    core_ack,
  output logic [DW-1:0]        core_rdata,
  output logic [NCORES-1:0]    core_stall,
  output logic                 core_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic                 mem_ready,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int IW = idx_w(NCORES);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  state_e              state_q, state_d;
  logic [IW-1:0]       id_q, id_d;
  logic [IW-1:0]       last_q, last_d;
  logic                we_q, we_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NCORES-1:0]   ack_q, ack_d;
  logic                err_q, err_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                req_q, req_d;

  logic [NCORES-1:0]   pick_grant;
  logic [IW-1:0]       pick_id;
  logic                timed_out;

  rr_pick #(
    .NCORES (NCORES),
    .IW     (IW)
  ) u_rr_pick (
    .req   (core_req),
    .last  (last_q),
    .grant (pick_grant),
    .id    (pick_id)
  );

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    ack_d     = ack_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    req_d     = req_q;
    timed_out = (TIMEOUT != 0) && (cnt_q == TMAX);

    case (state_q)
      IDLE: begin
        if (|pick_grant) begin
          id_d    = pick_id;
          we_d    = core_we[pick_id];
          addr_d  = core_addr[pick_id*AW +: AW];
          wdata_d = core_wdata[pick_id*DW +: DW];
          cnt_d   = '0;
          req_d   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // A real completion wins over a watchdog expiry in the same cycle.
        if (mem_ready || timed_out) begin
          req_d        = 1'b0;
          ack_d        = '0;
          ack_d[id_q]  = 1'b1;
          err_d        = ~mem_ready;
          last_d       = id_q;
          state_d      = DONE;
          if (!mem_ready) begin
            rdata_d = '0;
          end else if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end
      end
      DONE: begin
        ack_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      last_q  <= IW'(NCORES - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
    end
  end

  assign core_ack   = ack_q;
  assign core_err   = err_q;
  assign core_rdata = rdata_q;
  assign core_stall = core_req & ~ack_q;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a latency-programmable memory
module tb_mem_arbiter;

  localparam int NC = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NC-1:0]     core_req = '0;
  logic [NC-1:0]     core_we = '0;
  logic [NC*AW-1:0]  core_addr = '0;
  logic [NC*DW-1:0]  core_wdata = '0;
  logic [NC-1:0]     core_ack;
  logic [DW-1:0]     core_rdata;
  logic [NC-1:0]     core_stall;
  logic              core_err;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ready = 1'b0;
  logic [DW-1:0]     mem_rdata = '0;

  mem_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_ack   (core_ack),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .core_err   (core_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          core;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          gap;
  } ack_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  ack_t exp_ack[$];
  acc_t exp_acc[$];
  acc_t cq0[$];
  acc_t cq1[$];

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int last_ack_cyc = 0;
  int mem_lat = 1;
  bit mem_dead = 1'b0;
  logic req_prev = 1'b0;
  acc_t cur_acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE_0000 | 32'(a & 16'hFFFF);
  endfunction

  task automatic push(input int core, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input logic err, input int lat, input int gap);
    acc_t a;
    ack_t e;
    a.we = we; a.addr = addr; a.wdata = wdata;
    e.core = core; e.rdata = rdata; e.err = err; e.lat = lat; e.gap = gap;
    if (core == 0) cq0.push_back(a); else cq1.push_back(a);
    exp_acc.push_back(a);
    exp_ack.push_back(e);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (exp_ack.size() != 0 || cq0.size() != 0 || cq1.size() != 0); i++)
      @(negedge clk);
    chk("drain", 32'(exp_ack.size()), 32'd0);
    exp_ack.delete(); exp_acc.delete(); cq0.delete(); cq1.delete();
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  // Core-side driver: each core holds its head request until acked.
  always @(negedge clk) begin
    if (core_ack[0] && cq0.size() != 0) void'(cq0.pop_front());
    if (core_ack[1] && cq1.size() != 0) void'(cq1.pop_front());
    core_req[0] = (cq0.size() != 0);
    core_req[1] = (cq1.size() != 0);
    if (cq0.size() != 0) begin
      core_we[0] = cq0[0].we; core_addr[31:0] = cq0[0].addr; core_wdata[31:0] = cq0[0].wdata;
    end
    if (cq1.size() != 0) begin
      core_we[1] = cq1[0].we; core_addr[63:32] = cq1[0].addr; core_wdata[63:32] = cq1[0].wdata;
    end
  end

  // Memory model: ready after mem_lat BUSY cycles, random ready noise while idle.
  initial begin
    logic [31:0] mem_m [0:255];
    int bcnt;
    bcnt = 0;
    for (int i = 0; i < 256; i++) mem_m[i] = pat(i);
    mem_m[8'h10] = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        bcnt = 0;
      end else if (mem_dead) begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end else if (bcnt == mem_lat - 1) begin
        mem_ready = 1'b1;
        if (mem_we) mem_m[mem_addr[9:2]] = mem_wdata;
        else mem_rdata = mem_m[mem_addr[9:2]];
        bcnt = 0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        bcnt++;
      end
    end
  end

  // Monitor: grants, held payload, acks against the scoreboard.
  always @(negedge clk) begin
    acc_t a;
    ack_t e;
    if (!rst) begin
      if (core_req != '0) chk("stall", 32'(core_stall), 32'(core_req & ~core_ack));
      if (mem_req && !req_prev) begin
        rise_cyc = cyc;
        if (exp_acc.size() == 0) chk("acc_unexp", 32'(exp_acc.size()), 32'd1);
        else begin
          a = exp_acc.pop_front();
          cur_acc = a;
          chk("mem_we", 32'(mem_we), 32'(a.we));
          chk("mem_addr", mem_addr, a.addr);
          chk("mem_wdata", mem_wdata, a.wdata);
        end
      end else if (mem_req) begin
        chk("mem_hold", mem_addr, cur_acc.addr);
      end
      if (core_ack != '0) begin
        if (exp_ack.size() == 0) chk("ack_unexp", 32'(exp_ack.size()), 32'd1);
        else begin
          e = exp_ack.pop_front();
          chk("ack_id", 32'(core_ack), 32'(1) << e.core);
          chk("ack_rdata", core_rdata, e.rdata);
          chk("ack_err", 32'(core_err), 32'(e.err));
          chk("ack_lat", 32'(cyc - rise_cyc), 32'(e.lat));
          if (e.gap != 0) chk("ack_gap", 32'(cyc - last_ack_cyc), 32'(e.gap));
        end
        last_ack_cyc = cyc;
      end else if (core_err) begin
        chk("err_stray", 32'(core_err), 32'd0);
      end
    end
    req_prev = mem_req;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ack", 32'(core_ack), 32'd0);
    chk("rst_err", 32'(core_err), 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    rst = 1'b0;

    mem_lat = 3;
    push(0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
    repeat (2) @(negedge clk);
    chk("stall0_wait", 32'(core_stall[0]), 32'd1);
    drain(40);

    mem_lat = 2;
    push(1, 1'b1, 32'h8, 32'h1234, 32'hDEADBEEF, 1'b0, 2, 0);
    push(1, 1'b0, 32'h8, 32'h55AA, 32'h1234, 1'b0, 2, 0);
    drain(40);

    do_reset();
    push(0, 1'b0, 32'h10, 32'h0, pat(4), 1'b0, 2, 0);
    push(1, 1'b0, 32'h14, 32'h0, pat(5), 1'b0, 2, 0);
    drain(40);

    mem_lat = 1;
    for (int k = 0; k < 3; k++) begin
      push(0, 1'b0, 32'h20 + 32'(8 * k), 32'(k), pat(8 + 2 * k), 1'b0, 1, (k == 0) ? 0 : 3);
      push(1, 1'b0, 32'h24 + 32'(8 * k), 32'(k), pat(9 + 2 * k), 1'b0, 1, 3);
    end
    drain(60);

    mem_dead = 1'b1;
    push(0, 1'b0, 32'h60, 32'h0, 32'h0, 1'b1, TO + 1, 0);
    drain(40);
    mem_dead = 1'b0;
    push(1, 1'b0, 32'h64, 32'h0, pat(25), 1'b0, 1, 0);
    drain(40);

    push(0, 1'b0, 32'h70, 32'h0, pat(28), 1'b0, 1, 0);
    drain(40);
    mem_dead = 1'b1;
    push(1, 1'b1, 32'h74, 32'hFACE, 32'h0, 1'b0, 1, 0);
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    chk("busy_seen", 32'(mem_req), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_ack.delete(); exp_acc.delete(); cq0.delete(); cq1.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("mid_mem_req", 32'(mem_req), 32'd0);
    chk("mid_ack", 32'(core_ack), 32'd0);
    chk("mid_addr", mem_addr, 32'd0);
    chk("mid_we", 32'(mem_we), 32'd0);
    mem_dead = 1'b0;
    push(0, 1'b0, 32'h78, 32'h0, pat(30), 1'b0, 1, 0);
    push(1, 1'b0, 32'h7C, 32'h0, pat(31), 1'b0, 1, 3);
    drain(40);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
